// File: rtl/slot_config_sequencer.sv
// Programs slotmaker's slot/card configuration port from one of two slot maps,
// with single-slot runtime overrides. Optional status outputs: SLOT_CFG_STATUS_EN.
module slot_config_sequencer #(
  parameter logic [63:0] SLOT_MAP_DEFAULT = 64'h01000002_00030000,
  parameter logic [63:0] SLOT_MAP_ALT     = 64'h00000002_01030000,
  parameter int unsigned SETTLE_CYCLES    = 54000
) (
  input  logic        clk_logic,
  input  logic        device_reset_n,
  input  logic        alt_sel_i,
  input  logic        start_i,
  input  logic        ovr_req_i,
  input  logic [2:0]  ovr_slot_i,
  input  logic [7:0]  ovr_card_i,
  output logic        ovr_ack_o,
  output logic [2:0]  cfg_slot_o,
  output logic        cfg_wr_o,
  output logic [7:0]  cfg_card_o,
  output logic        cfg_reconfig_o,
  output logic        busy_o,
  output logic        done_o
`ifdef SLOT_CFG_STATUS_EN
  ,
  output logic [63:0] shadow_map_o,
  output logic [7:0]  reconfig_count_o
`endif
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {INIT, IDLE, SETTLE, WRITE, GAP, RECONFIG} state_t;

  state_t          state;
  logic            sel_meta;
  logic            sel_sync;
  logic            applied_sel;
  logic            pending_start;
  logic [1:0]      init_cnt;
  logic [CW-1:0]   settle_cnt;
  logic [3:0]      idx;
  logic            full_seq;
  logic            ovr_seq;
  logic [7:0][7:0] shadow;
  logic [7:0][7:0] map_sync;
  logic [7:0][7:0] map_applied;

  always_comb begin
    map_sync    = sel_sync    ? SLOT_MAP_ALT : SLOT_MAP_DEFAULT;
    map_applied = applied_sel ? SLOT_MAP_ALT : SLOT_MAP_DEFAULT;
  end

  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      sel_meta <= 1'b0;
      sel_sync <= 1'b0;
    end else begin
      sel_meta <= alt_sel_i;
      sel_sync <= sel_meta;
    end
  end

  // The state names what the registered outputs show this cycle; each branch
  // registers the outputs of the following cycle, so the first write of a
  // sequence leaves on the same edge that decides to start it.
  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      state          <= INIT;
      applied_sel    <= 1'b0;
      pending_start  <= 1'b0;
      init_cnt       <= '0;
      settle_cnt     <= '0;
      idx            <= '0;
      full_seq       <= 1'b0;
      ovr_seq        <= 1'b0;
      shadow         <= '0;
      ovr_ack_o      <= 1'b0;
      cfg_slot_o     <= '0;
      cfg_wr_o       <= 1'b0;
      cfg_card_o     <= '0;
      cfg_reconfig_o <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      if (start_i) pending_start <= 1'b1;
      case (state)
        INIT: begin
          busy_o <= 1'b1;
          if (init_cnt == 2'd2) begin
            applied_sel <= sel_sync;
            shadow      <= map_sync;
            cfg_wr_o    <= 1'b1;
            cfg_slot_o  <= '0;
            cfg_card_o  <= map_sync[0];
            idx         <= 4'd1;
            full_seq    <= 1'b1;
            ovr_seq     <= 1'b0;
            state       <= WRITE;
          end else begin
            init_cnt <= init_cnt + 2'd1;
          end
        end
        IDLE: begin
          if (pending_start || start_i) begin
            pending_start <= 1'b0;
            shadow        <= map_applied;
            cfg_wr_o      <= 1'b1;
            cfg_slot_o    <= '0;
            cfg_card_o    <= map_applied[0];
            idx           <= 4'd1;
            full_seq      <= 1'b1;
            ovr_seq       <= 1'b0;
            busy_o        <= 1'b1;
            state         <= WRITE;
          end else if (sel_sync != applied_sel) begin
            settle_cnt <= '0;
            state      <= SETTLE;
          end else if (ovr_req_i) begin
            shadow[ovr_slot_i] <= ovr_card_i;
            cfg_wr_o           <= 1'b1;
            cfg_slot_o         <= ovr_slot_i;
            cfg_card_o         <= ovr_card_i;
            full_seq           <= 1'b0;
            ovr_seq            <= 1'b1;
            busy_o             <= 1'b1;
            state              <= WRITE;
          end
        end
        SETTLE: begin
          if (sel_sync == applied_sel) begin
            state <= IDLE;
          end else if (settle_cnt == SETTLE_LAST) begin
            applied_sel <= sel_sync;
            shadow      <= map_sync;
            cfg_wr_o    <= 1'b1;
            cfg_slot_o  <= '0;
            cfg_card_o  <= map_sync[0];
            idx         <= 4'd1;
            full_seq    <= 1'b1;
            ovr_seq     <= 1'b0;
            busy_o      <= 1'b1;
            state       <= WRITE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        WRITE: begin
          if (full_seq && idx != 4'd8) begin
            cfg_slot_o <= idx[2:0];
            cfg_card_o <= shadow[idx[2:0]];
            idx        <= idx + 4'd1;
          end else begin
            cfg_wr_o <= 1'b0;
            state    <= GAP;
          end
        end
        GAP: begin
          cfg_reconfig_o <= 1'b1;
          if (full_seq) done_o <= 1'b1;
          if (ovr_seq) ovr_ack_o <= 1'b1;
          state <= RECONFIG;
        end
        RECONFIG: begin
          cfg_reconfig_o <= 1'b0;
          ovr_ack_o      <= 1'b0;
          busy_o         <= 1'b0;
          full_seq       <= 1'b0;
          ovr_seq        <= 1'b0;
          state          <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef SLOT_CFG_STATUS_EN
  assign shadow_map_o = shadow;

  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) reconfig_count_o <= '0;
    else if (state == GAP) reconfig_count_o <= reconfig_count_o + 8'd1;
  end
`endif

endmodule
